// File: rtl/svlib_arith_pkg.sv
// svlib_arith_pkg: shared mode type and negate-flag helper for the arith library (twoscomp_pipe)
package svlib_arith_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_NEG  = 2'd1,
        MODE_ABS  = 2'd2,
        MODE_NABS = 2'd3
    } twoscomp_mode_e;

    // Whether a lane with sign bit msb gets negated under the given mode.
    function automatic logic neg_flag(twoscomp_mode_e mode, logic msb);
        return (mode == MODE_NEG) || (mode == MODE_ABS && msb) || (mode == MODE_NABS && !msb);
    endfunction

endpackage

// File: rtl/twoscomp_chunk.sv
// twoscomp_chunk: combinational invert-above-first-set-bit negation of one CW-bit chunk
module twoscomp_chunk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] chunk,
    input  logic          neg,
    input  logic          any_in,
    output logic [CW-1:0] chunk_out,
    output logic          any_out
);

    logic [CW:0] seen;

    // seen[i]: some bit below position i (including lower chunks) is set.
    always_comb begin
        seen[0] = any_in;
        for (int i = 0; i < CW; i++) seen[i+1] = seen[i] | chunk[i];
    end

    assign chunk_out = chunk ^ ({CW{neg}} & seen[CW-1:0]);
    assign any_out   = seen[CW];

endmodule

// File: rtl/twoscomp_pipe.sv
// twoscomp_pipe: multi-lane pipelined pass/neg/abs/nabs; macro TWOSCOMP_SAT_EN saturates overflow to max positive
module twoscomp_pipe
    import svlib_arith_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LANES  = 2,
    parameter int STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_mode,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_ovf
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LW   = LANES * WIDTH;
    localparam int LAST = STAGES - 1;
    localparam logic [CW-1:0] LOW_MASK = {CW{1'b1}} >> 1;
`ifdef TWOSCOMP_SAT_EN
    localparam logic [WIDTH-1:0] SAT_VAL = {1'b0, {(WIDTH-1){1'b1}}};
`endif

    if (WIDTH % STAGES != 0 || STAGES < 1 || STAGES > 8) begin : g_bad_cfg
        $error("twoscomp_pipe: WIDTH must be a multiple of STAGES and STAGES in 1..8");
    end

    function automatic logic [LANES-1:0] neg_vec(logic [1:0] mode, logic [LW-1:0] d);
        logic [LANES-1:0] v;
        for (int k = 0; k < LANES; k++) v[k] = neg_flag(twoscomp_mode_e'(mode), d[k*WIDTH+WIDTH-1]);
        return v;
    endfunction

    logic             vld_q    [STAGES];
    logic [LW-1:0]    data_q   [STAGES];
    logic [LANES-1:0] neg_q    [STAGES];
    logic [LANES-1:0] any_q    [STAGES];
    logic             src_vld  [STAGES];
    logic [LW-1:0]    src_data [STAGES];
    logic [LW-1:0]    nxt_data [STAGES];
    logic [LANES-1:0] src_neg  [STAGES];
    logic [LANES-1:0] src_any  [STAGES];
    logic [LANES-1:0] nxt_any  [STAGES];
    logic [LANES-1:0] nxt_ovf;
    logic [LANES-1:0] ovf_q;
    logic [STAGES:0]  adv;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [CW-1:0]    co [LANES];
        logic [LANES-1:0] ao;
        logic [LW-1:0]    res;
        if (s == 0) begin : g_src
            assign src_vld[s]  = in_valid;
            assign src_data[s] = in_data;
            assign src_neg[s]  = neg_vec(in_mode, in_data);
            assign src_any[s]  = '0;
        end else begin : g_src
            assign src_vld[s]  = vld_q[s-1];
            assign src_data[s] = data_q[s-1];
            assign src_neg[s]  = neg_q[s-1];
            assign src_any[s]  = any_q[s-1];
        end
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            twoscomp_chunk #(.CW(CW)) u_chunk (
                .chunk    (src_data[s][k*WIDTH+s*CW +: CW]),
                .neg      (src_neg[s][k]),
                .any_in   (src_any[s][k]),
                .chunk_out(co[k]),
                .any_out  (ao[k])
            );
            if (s == LAST) begin : g_ovf
                // ao & ~(set bits below MSB) leaves exactly "only the MSB is set".
                assign nxt_ovf[k] = src_neg[s][k] & ao[k]
                                  & ~(src_any[s][k] | |(src_data[s][k*WIDTH+s*CW +: CW] & LOW_MASK));
            end
        end
        // Splice this stage's chunk results into the word; upper chunks ride along untouched.
        always_comb begin
            res = src_data[s];
            for (int k = 0; k < LANES; k++) begin
                res[k*WIDTH+s*CW +: CW] = co[k];
`ifdef TWOSCOMP_SAT_EN
                if (s == LAST && nxt_ovf[k]) res[k*WIDTH +: WIDTH] = SAT_VAL;
`endif
            end
        end
        assign nxt_data[s] = res;
        assign nxt_any[s]  = ao;
    end

    // Load enables ripple back from the output: a stage may load if empty or its successor moves.
    always_comb begin
        adv[STAGES] = out_ready;
        for (int s = STAGES - 1; s >= 0; s--) adv[s] = ~vld_q[s] | adv[s+1];
    end

    // Pipeline registers; every stage advances independently so bubbles collapse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                vld_q[s]  <= 1'b0;
                data_q[s] <= '0;
                neg_q[s]  <= '0;
                any_q[s]  <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (adv[s]) begin
                    vld_q[s]  <= src_vld[s];
                    data_q[s] <= nxt_data[s];
                    neg_q[s]  <= src_neg[s];
                    any_q[s]  <= nxt_any[s];
                end
            end
            if (adv[LAST]) ovf_q <= nxt_ovf;
        end
    end

    assign in_ready  = rst_n & adv[0];
    assign out_valid = vld_q[LAST];
    assign out_data  = data_q[LAST];
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_twoscomp_pipe.sv
// tb_twoscomp_pipe: table vectors, stall/reset sequences and random traffic against a scoreboard
module tb_twoscomp_pipe;

    localparam int W  = 8;
    localparam int L  = 2;
    localparam int S  = 2;
    localparam int LW = W * L;
`ifdef TWOSCOMP_SAT_EN
    localparam logic [7:0] OV = 8'h7F;
`else
    localparam logic [7:0] OV = 8'h80;
`endif

    typedef struct {
        logic [1:0]    mode;
        logic [LW-1:0] din;
        logic [LW-1:0] dout;
        logic [L-1:0]  ovf;
    } vec_t;

    logic          clk = 0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_mode;
    logic [LW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] out_data;
    logic [L-1:0]  out_ovf;

    int total = 0;
    int bad = 0;
    logic [L+LW-1:0] exp_q [$];
    logic [L+LW-1:0] want;
    logic [L+LW-1:0] prev_out;
    logic            prev_stall = 0;
    vec_t            tbl [12];

    twoscomp_pipe #(.WIDTH(W), .LANES(L), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [L+LW-1:0] model(logic [1:0] m, logic [LW-1:0] d);
        logic [LW-1:0] y = '0;
        logic [L-1:0]  o = '0;
        logic [W-1:0]  x, r;
        logic          n;
        for (int k = 0; k < L; k++) begin
            x = d[k*W +: W];
            n = (m == 2'd1) || (m == 2'd2 && x[W-1]) || (m == 2'd3 && !x[W-1]);
            r = n ? W'(0) - x : x;
            o[k] = n && (x == {1'b1, {(W-1){1'b0}}});
`ifdef TWOSCOMP_SAT_EN
            if (o[k]) r = {1'b0, {(W-1){1'b1}}};
`endif
            y[k*W +: W] = r;
        end
        return {o, y};
    endfunction

    function automatic logic [LW-1:0] rand_data();
        logic [LW-1:0] d;
        int r;
        for (int k = 0; k < L; k++) begin
            r = $urandom_range(0, 7);
            d[k*W +: W] = r == 0 ? 8'h80 : r == 1 ? 8'h00 : r == 2 ? 8'h7F : r == 3 ? 8'hFF : W'($urandom);
        end
        return d;
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic send(logic [1:0] m, logic [LW-1:0] d, logic [L+LW-1:0] e);
        int n = 0;
        @(negedge clk);
        in_valid = 1; in_mode = m; in_data = d;
        #1;
        while (!in_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL send_timeout got=in_ready0 want=in_ready1");
        end else exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk); n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'(0));
    endtask

    // Scoreboard monitor: samples mid-cycle, pops on handshake, checks hold while stalled.
    always @(negedge clk) begin
        #3;
        if (!rst_n) prev_stall = 0;
        else begin
            if (prev_stall) begin
                total++;
                if (!out_valid || {out_ovf, out_data} !== prev_out) begin
                    bad++;
                    $display("FAIL stall_hold got v=%b %h want v=1 %h", out_valid, {out_ovf, out_data}, prev_out);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out got=%h want=none", {out_ovf, out_data});
                end else begin
                    want = exp_q.pop_front();
                    if ({out_ovf, out_data} !== want) begin
                        bad++;
                        $display("FAIL scoreboard got ovf=%b data=%h want ovf=%b data=%h",
                                 out_ovf, out_data, want[L+LW-1:LW], want[LW-1:0]);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_ovf, out_data};
        end
    end

    initial begin
        logic [L+LW-1:0] hold;
        int stalls, stale;
        tbl[0]  = '{2'd1, 16'h0105, 16'hFFFB,     2'b00};
        tbl[1]  = '{2'd2, 16'hF680, {8'h0A, OV},  2'b01};
        tbl[2]  = '{2'd3, 16'h0380, 16'hFD80,     2'b00};
        tbl[3]  = '{2'd0, 16'h009C, 16'h009C,     2'b00};
        tbl[4]  = '{2'd1, 16'h7F00, 16'h8100,     2'b00};
        tbl[5]  = '{2'd1, 16'h8080, {OV, OV},     2'b11};
        tbl[6]  = '{2'd2, 16'h7F81, 16'h7F7F,     2'b00};
        tbl[7]  = '{2'd3, 16'h0001, 16'h00FF,     2'b00};
        tbl[8]  = '{2'd0, 16'h8080, 16'h8080,     2'b00};
        tbl[9]  = '{2'd1, 16'h0110, 16'hFFF0,     2'b00};
        tbl[10] = '{2'd1, 16'h0008, 16'h00F8,     2'b00};
        tbl[11] = '{2'd2, 16'h0080, {8'h00, OV},  2'b01};

        rst_n = 0; in_valid = 0; in_mode = 0; in_data = 0; out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_ovf", 64'(out_ovf), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst_n = 1;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'(1));

        // Latency: NEG {05,01} lands exactly two edges after acceptance.
        in_valid = 1; in_mode = 2'd1; in_data = 16'h0105;
        exp_q.push_back({2'b00, 16'hFFFB});
        @(posedge clk); #1;
        in_valid = 0;
        check("lat1_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        check("lat2_valid", 64'(out_valid), 64'(1));
        check("lat2_out", 64'({out_ovf, out_data}), 64'({2'b00, 16'hFFFB}));
        drain();

        for (int i = 0; i < 12; i++) send(tbl[i].mode, tbl[i].din, {tbl[i].ovf, tbl[i].dout});
        drain();

        // Backpressure: two beats fill the pipe, third is refused until release.
        @(negedge clk);
        out_ready = 0; in_valid = 1; in_mode = 2'd0; in_data = 16'h1122;
        #1;
        check("stall_rdy_a", 64'(in_ready), 64'(1));
        exp_q.push_back({2'b00, 16'h1122});
        @(negedge clk);
        in_mode = 2'd1; in_data = 16'h3344;
        #1;
        check("stall_rdy_b", 64'(in_ready), 64'(1));
        exp_q.push_back({2'b00, 16'hCDBC});
        @(negedge clk);
        in_mode = 2'd2; in_data = 16'h80F0;
        #1;
        check("stall_full", 64'(in_ready), 64'(0));
        hold = {out_ovf, out_data};
        check("stall_head", 64'(hold), 64'({2'b00, 16'h1122}));
        repeat (3) begin
            @(posedge clk); #1;
            check("stall_stable", 64'({out_valid, out_ovf, out_data}), 64'({1'b1, hold}));
        end
        @(negedge clk);
        out_ready = 1;
        #1;
        check("stall_release_rdy", 64'(in_ready), 64'(1));
        exp_q.push_back({2'b10, OV, 8'h10});
        @(posedge clk); #1;
        in_valid = 0;
        drain();

        // Full rate with downstream always ready.
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            in_valid = 1; in_mode = 2'($urandom); in_data = rand_data();
            #1;
            if (!in_ready) stalls++;
            else exp_q.push_back(model(in_mode, in_data));
        end
        @(negedge clk);
        in_valid = 0;
        check("full_rate_stalls", 64'(stalls), 64'(0));
        drain();

        // Random valid/ready traffic.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            out_ready = $urandom_range(0, 3) != 0;
            in_valid  = $urandom_range(0, 2) != 0;
            in_mode   = 2'($urandom);
            in_data   = rand_data();
            #1;
            if (in_valid && in_ready) exp_q.push_back(model(in_mode, in_data));
        end
        @(negedge clk);
        in_valid = 0; out_ready = 1;
        drain();

        // Reset with two beats in flight discards them.
        @(negedge clk);
        in_valid = 1; in_mode = 2'd1; in_data = 16'h0102;
        @(negedge clk);
        in_data = 16'h0304;
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        rst_n = 0;
        exp_q.delete();
        @(posedge clk); #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_out_data", 64'(out_data), 64'(0));
        check("midrst_out_ovf", 64'(out_ovf), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst_n = 1;
        stale = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        check("midrst_no_stale", 64'(stale), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
